// File: rtl/pwm_decoder.sv
// PWM decoder: recovers high time and period of a PWM input, flags a stuck input.
// Optional build macro PWM_DECODER_SYNC_EN adds a two-flop input synchronizer.
module pwm_decoder #(
  parameter int WIDTH  = 8,
  parameter int INVERT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH:0]   period,
  output logic             valid,
  output logic             stuck
);

  localparam logic [WIDTH:0]   CNT_MAX = {(WIDTH+1){1'b1}};
  localparam logic [WIDTH-1:0] LVL_MAX = {WIDTH{1'b1}};
  localparam logic             INV_BIT = (INVERT != 0);

  typedef enum logic [1:0] {IDLE, MEAS, STUCK} state_t;

  state_t           state, next_state;
  logic             s_raw, s, s_d, rise;
  logic [WIDTH:0]   pcnt, hcnt, pcnt_next, hcnt_next;
  logic [WIDTH-1:0] level_next;
  logic [WIDTH:0]   period_next;
  logic             valid_next, stuck_next;

`ifdef PWM_DECODER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], pwm_in};
  end

  assign s_raw = sync_q[1];
`else
  assign s_raw = pwm_in;
`endif

  assign s    = s_raw ^ INV_BIT;
  assign rise = s & ~s_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      s_d    <= 1'b0;
      pcnt   <= '0;
      hcnt   <= '0;
      level  <= '0;
      period <= '0;
      valid  <= 1'b0;
      stuck  <= 1'b0;
    end else begin
      state  <= next_state;
      s_d    <= s;
      pcnt   <= pcnt_next;
      hcnt   <= hcnt_next;
      level  <= level_next;
      period <= period_next;
      valid  <= valid_next;
      stuck  <= stuck_next;
    end
  end

  // Counters restart at 1 on a rise so the next rise sees exactly the period length
  always_comb begin
    pcnt_next = (pcnt == CNT_MAX) ? CNT_MAX : pcnt + 1'b1;
    hcnt_next = hcnt;
    if (s && hcnt != CNT_MAX) hcnt_next = hcnt + 1'b1;
    if (rise) begin
      pcnt_next = {{WIDTH{1'b0}}, 1'b1};
      hcnt_next = {{WIDTH{1'b0}}, 1'b1};
    end
  end

  always_comb begin
    next_state  = state;
    level_next  = level;
    period_next = period;
    valid_next  = 1'b0;
    stuck_next  = stuck;
    case (state)
      IDLE, MEAS: begin
        if (rise) begin
          next_state = MEAS;
          if (state == MEAS) begin
            level_next  = hcnt[WIDTH] ? LVL_MAX : hcnt[WIDTH-1:0];
            period_next = pcnt;
            valid_next  = 1'b1;
          end
        end else if (pcnt == CNT_MAX) begin
          next_state  = STUCK;
          level_next  = s ? LVL_MAX : '0;
          period_next = '0;
          stuck_next  = 1'b1;
          valid_next  = 1'b1;
        end
      end
      STUCK: begin
        if (rise) begin
          next_state = MEAS;
          stuck_next = 1'b0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
